// File: rtl/param_width_packer.sv
// Narrow-to-wide packer: gathers RATIO beats of N_IN bits into one N_IN*RATIO-bit word.
// Optional partial-word flush is built in when the PACKER_FLUSH_EN macro is defined.
module param_width_packer #(
  parameter int unsigned N_IN      = 3,
  parameter int unsigned RATIO     = 4,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_IN-1:0]              in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N_IN*RATIO-1:0]        out_data,
  output logic [$clog2(RATIO+1)-1:0]   out_beats
`ifdef PACKER_FLUSH_EN
  ,
  input  logic                         flush
`endif
);

  localparam int unsigned N_OUT = N_IN * RATIO;
  localparam int unsigned CW    = $clog2(RATIO);
  localparam int unsigned BW    = $clog2(RATIO + 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_OUT-1:0] acc_q, acc_d;
  logic             out_valid_q, out_valid_d;
  logic [N_OUT-1:0] out_data_q, out_data_d;
  logic [BW-1:0]    out_beats_q, out_beats_d;

  logic             last_beat;
  logic             out_free;
  logic             in_accept;
  logic [N_OUT-1:0] merged;

  // Accumulator with the incoming beat dropped into the slot selected by cnt.
  always_comb begin
    merged = acc_q;
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (CW'(k) == cnt_q) begin
        if (MSB_FIRST) begin
          merged[(RATIO-1-k)*N_IN +: N_IN] = in_data;
        end else begin
          merged[k*N_IN +: N_IN] = in_data;
        end
      end
    end
  end

  // Handshake: only the completing beat can be blocked by an unconsumed word.
  always_comb begin
    last_beat = (cnt_q == CW'(RATIO - 1));
    out_free  = !out_valid_q || out_ready;
`ifdef PACKER_FLUSH_EN
    in_ready  = (!last_beat || out_free) && !(flush && out_valid_q && !out_ready);
`else
    in_ready  = !last_beat || out_free;
`endif
    in_accept = in_valid && in_ready;
  end

  // Next-state: fill slots, complete words, release taken words, optional flush.
  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_beats_d = out_beats_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (in_accept) begin
      if (last_beat) begin
        out_data_d  = merged;
        out_valid_d = 1'b1;
        out_beats_d = BW'(RATIO);
        cnt_d       = '0;
        acc_d       = '0;
      end else begin
        acc_d = merged;
        cnt_d = cnt_q + CW'(1);
`ifdef PACKER_FLUSH_EN
        if (flush && out_free) begin
          out_data_d  = merged;
          out_valid_d = 1'b1;
          out_beats_d = BW'(cnt_q) + BW'(1);
          cnt_d       = '0;
          acc_d       = '0;
        end
`endif
      end
    end
`ifdef PACKER_FLUSH_EN
    else if (flush && (cnt_q != '0) && out_free) begin
      out_data_d  = acc_q;
      out_valid_d = 1'b1;
      out_beats_d = BW'(cnt_q);
      cnt_d       = '0;
      acc_d       = '0;
    end
`endif
  end

  // State registers; reset discards any partial word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_beats_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_beats_q <= out_beats_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_beats = out_beats_q;

endmodule
